// File: rtl/weight_ram_writer_pkg.sv
// weight_ram_writer_pkg: shared states, default geometry and kernel placement for the weight writer/reader pair
package weight_ram_writer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam int DW_DEF             = 8;
  localparam int ROM_NUM_DEF        = 6;
  localparam int ROM_SIZE_DEF       = 25;
  localparam int KERNEL_ELEMENT_DEF = 15;
  localparam int ABS_ADDR_DW_DEF    = 16;
  typedef struct packed {
    logic [15:0] bank;
    logic [15:0] addr;
  } place_t;
  function automatic place_t place(input int k, input int e);
    place_t p;
    p.bank = 16'(k % ROM_NUM_DEF);
    p.addr = 16'((k / ROM_NUM_DEF) * KERNEL_ELEMENT_DEF + e);
    return p;
  endfunction
endpackage

// File: rtl/weight_ram_writer_if.sv
// weight_ram_writer_if: host stream, control and bank write bus of the weight writer
// checksum exists only when WEIGHT_WR_CHECKSUM_EN is defined
interface weight_ram_writer_if #(
  parameter int DW          = 8,
  parameter int ROM_NUM     = 6,
  parameter int ABS_ADDR_DW = 16
);
  logic                   start;
  logic [15:0]            kernel_num;
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic [ROM_NUM-1:0]     wr_en;
  logic [ABS_ADDR_DW-1:0] wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   busy;
  logic                   done;
  logic                   err;
`ifdef WEIGHT_WR_CHECKSUM_EN
  logic [DW+15:0]         checksum;
  modport slave (
    input  start, kernel_num, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err, checksum
  );
  modport master (
    output start, kernel_num, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, checksum
  );
`else
  modport slave (
    input  start, kernel_num, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
  modport master (
    output start, kernel_num, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
`endif
endinterface

// File: rtl/weight_ram_writer_addr_gen.sv
// weight_ram_writer_addr_gen: element/bank/fold/kernel counters mapping stream position to bank and address
module weight_ram_writer_addr_gen #(
  parameter int ROM_NUM        = 6,
  parameter int KERNEL_ELEMENT = 15,
  parameter int ABS_ADDR_DW    = 16,
  localparam int BW = ROM_NUM > 1 ? $clog2(ROM_NUM) : 1,
  localparam int EW = KERNEL_ELEMENT > 1 ? $clog2(KERNEL_ELEMENT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [15:0]            kernel_num,
  output logic [BW-1:0]          bank,
  output logic [ABS_ADDR_DW-1:0] addr,
  output logic                   last
);
  logic [EW-1:0]          elem_cnt;
  logic [BW-1:0]          bank_cnt;
  logic [ABS_ADDR_DW-1:0] base_addr;
  logic [15:0]            kern_cnt;
  logic [15:0]            kern_total;
  logic                   elem_wrap;
  logic                   bank_wrap;
  assign elem_wrap = elem_cnt == EW'(KERNEL_ELEMENT - 1);
  assign bank_wrap = bank_cnt == BW'(ROM_NUM - 1);
  assign bank      = bank_cnt;
  assign addr      = base_addr + ABS_ADDR_DW'(elem_cnt);
  assign last      = elem_wrap && kern_cnt == kern_total - 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt   <= '0;
      bank_cnt   <= '0;
      base_addr  <= '0;
      kern_cnt   <= '0;
      kern_total <= '0;
    end else if (clear) begin
      elem_cnt   <= '0;
      bank_cnt   <= '0;
      base_addr  <= '0;
      kern_cnt   <= '0;
      kern_total <= kernel_num;
    end else if (advance) begin
      elem_cnt <= elem_wrap ? '0 : elem_cnt + 1'b1;
      if (elem_wrap) begin
        bank_cnt  <= bank_wrap ? '0 : bank_cnt + 1'b1;
        base_addr <= bank_wrap ? base_addr + ABS_ADDR_DW'(KERNEL_ELEMENT) : base_addr;
        kern_cnt  <= kern_cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/weight_ram_writer.sv
// weight_ram_writer: scatters a kernel-major weight stream over ROM_NUM banks (kernel k -> bank k mod ROM_NUM)
// Define WEIGHT_WR_CHECKSUM_EN to add a running checksum of accepted weights.
module weight_ram_writer
  import weight_ram_writer_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int ROM_NUM        = ROM_NUM_DEF,
  parameter int ROM_SIZE       = ROM_SIZE_DEF,
  parameter int KERNEL_ELEMENT = KERNEL_ELEMENT_DEF,
  parameter int ABS_ADDR_DW    = ABS_ADDR_DW_DEF
) (
  input logic                clk,
  input logic                rst_n,
  weight_ram_writer_if.slave bus
);
  localparam int BW = ROM_NUM > 1 ? $clog2(ROM_NUM) : 1;
  localparam logic [ABS_ADDR_DW-1:0] ADDR_MAX = ABS_ADDR_DW'(ROM_SIZE - 1);
  state_t                 state;
  state_t                 next;
  logic [BW-1:0]          bank;
  logic [ABS_ADDR_DW-1:0] addr;
  logic                   last;
  logic                   go;
  logic                   xfer;
  logic                   ovf;
  assign go   = state == IDLE && bus.start;
  assign xfer = state == LOAD && bus.in_valid;
  assign ovf  = addr > ADDR_MAX;
  weight_ram_writer_addr_gen #(
    .ROM_NUM        (ROM_NUM),
    .KERNEL_ELEMENT (KERNEL_ELEMENT),
    .ABS_ADDR_DW    (ABS_ADDR_DW)
  ) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (go),
    .advance    (xfer),
    .kernel_num (bus.kernel_num),
    .bank       (bank),
    .addr       (addr),
    .last       (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  always_comb begin
    next         = state;
    bus.in_ready = state == LOAD;
    bus.busy     = state == LOAD || state == FLUSH;
    bus.done     = state == DONE;
    unique case (state)
      IDLE:  next = bus.start ? (bus.kernel_num != 16'd0 ? LOAD : DONE) : IDLE;
      LOAD:  next = xfer && last ? FLUSH : LOAD;
      FLUSH: next = DONE;
      DONE:  next = IDLE;
    endcase
  end
  // out-of-range transfers are consumed but never reach a bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.wr_en <= xfer && !ovf ? ROM_NUM'(1) << bank : '0;
      if (xfer) begin
        bus.wr_addr <= addr;
        bus.wr_data <= bus.in_data;
      end
      bus.err <= go ? 1'b0 : bus.err | (xfer && ovf);
    end
  end
`ifdef WEIGHT_WR_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bus.checksum <= '0;
    else if (go)   bus.checksum <= '0;
    else if (xfer) bus.checksum <= bus.checksum + (DW+16)'(bus.in_data);
  end
`endif
endmodule

// File: tb/tb_weight_ram_writer.sv
// tb_weight_ram_writer: directed/random loads checked against an arithmetic placement model
module tb_weight_ram_writer;
  localparam int KE = 15;
  localparam int RN = 6;
  localparam int RS = 25;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0;
  int mismatched = 0;
  bit exp_err;
  logic [23:0] exp_sum;
  weight_ram_writer_if #(.DW(8), .ROM_NUM(RN), .ABS_ADDR_DW(16)) bus ();
  weight_ram_writer #(
    .DW(8), .ROM_NUM(RN), .ROM_SIZE(RS), .KERNEL_ELEMENT(KE), .ABS_ADDR_DW(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
`ifdef WEIGHT_WR_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(bus.checksum), 0);
`endif
  endtask

  // stream index pn -> kernel, element -> bank, address
  task automatic check_wr(input bit pend, input int pn, input logic [7:0] pd);
    int k, e, bk, ad;
    bit ok;
    k  = pn / KE;
    e  = pn % KE;
    bk = k % RN;
    ad = (k / RN) * KE + e;
    ok = ad <= RS - 1;
    if (pend) begin
      if (!ok) exp_err = 1'b1;
      chk("wr_en", 32'(bus.wr_en), ok ? (32'd1 << bk) : 32'd0);
      chk("wr_addr", 32'(bus.wr_addr), 32'(ad));
      chk("wr_data", 32'(bus.wr_data), 32'(pd));
    end else chk("stall_wr_en", 32'(bus.wr_en), 0);
    chk("err", 32'(bus.err), 32'(exp_err));
  endtask

  task automatic run(input int kn, input bit stall, input int abort_at);
    int total, n, cyc, pn;
    bit pend, v;
    logic [7:0] d, pd;
    total = kn * KE; n = 0; cyc = 0; pend = 0; pn = 0; pd = '0;
    exp_err = 1'b0; exp_sum = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.kernel_num = 16'(kn);
    @(negedge clk);
    bus.start = 1'b0;
    if (kn == 0) begin
      chk("zero_done", 32'(bus.done), 1);
      chk("zero_ready", 32'(bus.in_ready), 0);
      chk("zero_wr_en", 32'(bus.wr_en), 0);
      chk("zero_err", 32'(bus.err), 0);
      @(negedge clk);
      chk("zero_done_drop", 32'(bus.done), 0);
      chk("zero_wr_en2", 32'(bus.wr_en), 0);
      return;
    end
    while (n < total && cyc < 4000) begin
      chk("ready", 32'(bus.in_ready), 1);
      chk("busy", 32'(bus.busy), 1);
      chk("done_early", 32'(bus.done), 0);
      check_wr(pend, pn, pd);
      if (n == abort_at) begin
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      d = stall ? 8'($urandom) : 8'(n);
      bus.in_valid = v; bus.in_data = d;
      pend = v; pn = n; pd = d;
      if (v) begin
        n++;
        exp_sum += 24'(d);
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_wr(pend, pn, pd);
    chk("flush_busy", 32'(bus.busy), 1);
    chk("flush_done", 32'(bus.done), 0);
    chk("flush_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("done", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_wr_en", 32'(bus.wr_en), 0);
    chk("done_err", 32'(bus.err), 32'(exp_err));
`ifdef WEIGHT_WR_CHECKSUM_EN
    chk("checksum", 32'(bus.checksum), 32'(exp_sum));
`endif
    @(negedge clk);
    chk("done_drop", 32'(bus.done), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.kernel_num = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(6, 1'b0, -1);
`ifdef WEIGHT_WR_CHECKSUM_EN
    chk("checksum_4005", 32'(exp_sum), 32'(bus.checksum));
    chk("checksum_const", 32'(bus.checksum), 4005);
`endif
    run(8, 1'b0, -1);
    chk("err_sticky", 32'(bus.err), 1);
    run(0, 1'b0, -1);
    run(2, 1'b1, -1);
    run(3, 1'b1, -1);
    run(6, 1'b0, 40);
    run(6, 1'b0, -1);
    run(7, 1'b1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/weight_ram_writer.md
Name: weight_ram_writer

Overview:
- Loads a kernel-major serial weight stream (kernel k, elements 0..KERNEL_ELEMENT-1) into ROM_NUM per-column weight banks.
- Placement matches what the array-side weight reader expects: kernel k → bank k mod ROM_NUM, address (k div ROM_NUM)*KERNEL_ELEMENT + e.
- Sits between the host/DMA weight stream and the weight banks; the reader later fetches with base_addr = fold*KERNEL_ELEMENT and rom_select = fold*ROM_NUM.

Parameters:
- DW, 8, weight width in bits
- ROM_NUM, 6, number of weight banks (one per array column)
- ROM_SIZE, 25, words per bank; highest legal address is ROM_SIZE-1
- KERNEL_ELEMENT, 15, weights per kernel
- ABS_ADDR_DW, 16, bank address width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a load, sampled only in IDLE
- kernel_num  in  16  number of kernels to load, latched on start
- in_valid  in  1  stream data valid
- in_data  in  DW  weight value
- in_ready  out  1  writer accepts in_data
- wr_en  out  ROM_NUM  one-hot bank write strobe, registered
- wr_addr  out  ABS_ADDR_DW  bank address, registered, shared by all banks
- wr_data  out  DW  write data, registered
- busy  out  1  high in LOAD and FLUSH
- done  out  1  one-cycle pulse when the load completes
- err  out  1  sticky overflow flag; cleared by the next accepted start

Behaviour:
- Reset values (asynchronous): state=IDLE, all counters 0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
- States and transitions:
  - IDLE → LOAD on start when kernel_num != 0.
  - IDLE → DONE on start when kernel_num == 0; no writes are issued.
  - LOAD → FLUSH when the last element of the last kernel is accepted.
  - FLUSH → DONE after one cycle, which drains the write register.
  - DONE → IDLE after one cycle; done=1 only while in DONE.
- Handshake:
  - in_ready=1 exactly in LOAD.
  - A transfer occurs on a cycle with in_valid && in_ready.
  - in_valid may drop at any time; counters hold while stalled.
- Counters:
  - elem_cnt counts 0..KERNEL_ELEMENT-1.
  - bank_cnt counts 0..ROM_NUM-1.
  - base_addr advances by KERNEL_ELEMENT.
  - kern_cnt counts 0..kernel_num-1.
  - When elem_cnt wraps, bank_cnt increments. When bank_cnt wraps, base_addr += KERNEL_ELEMENT.
- Address arithmetic: addr = base_addr + elem_cnt, computed at ABS_ADDR_DW width.
- Write latency is exactly 1 cycle after the transfer:
  - wr_en = one-hot(bank_cnt).
  - wr_addr = addr.
  - wr_data = in_data.
  - wr_en = 0 on cycles with no transfer.
- Overflow:
  - A transfer with addr > ROM_SIZE-1 suppresses wr_en for that transfer and sets err.
  - The stream is still consumed to the end and done still pulses.
- Partial last fold: when kernel_num is not a multiple of ROM_NUM, the remaining banks of the last fold receive no writes; the reader zero-fills them.
- start while busy is ignored.
- Reset mid-load returns everything to the reset values. A partially written bank keeps its stale contents and must be reloaded.

Optional Feature:
- Macro: WEIGHT_WR_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum [DW+15:0] holds the running modulo-2^(DW+16) sum of all accepted in_data.
  - checksum is cleared on an accepted start.
  - The value is final and stable when done=1 and holds until the next accepted start.
- Without the macro: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared weight package holds:
  - State encoding constants (IDLE, LOAD, FLUSH, DONE).
  - Default DW/ROM_NUM/KERNEL_ELEMENT/ROM_SIZE constants shared with the reader.
  - The placement function bank = k mod ROM_NUM, addr = fold*KERNEL_ELEMENT + e.
- One natural sub-module: weight_addr_gen, holding elem/bank/base/kern counters with an advance input, and outputs bank, addr, last.

Test Plan:
- Default params, kernel_num=6, 90 back-to-back weights 0..89 → bank m gets addresses 0..14 with data 15m..15m+14; done 2 cycles after the last transfer; err=0.
- kernel_num=8 → kernels 6,7 go to banks 0,1 at addresses 15..29; addresses 25..29 exceed ROM_SIZE-1=24, so they are dropped, err=1, and done still pulses.
- kernel_num=2, in_valid toggling 1-0-1 pseudo-randomly → same bank/address/data contents as the unstalled run; wr_en never asserts on stall cycles.
- start with kernel_num=0 → no wr_en, in_ready stays 0, done pulses the cycle after start.
- rst_n low after 40 transfers → all outputs at reset values immediately; a new start then reloads correctly from bank 0, address 0.
- WEIGHT_WR_CHECKSUM_EN, kernel_num=6, data 0..89 → checksum=4005 while done=1.
